// File: rtl/instr_register_arbiter.sv
// rtl/instr_register_arbiter.sv - round-robin two-port write arbiter and pointer sequencer
// feeding instr_register.
module instr_register_arbiter #(
  parameter int DEPTH     = 32,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  input  logic [3:0]         req0_opcode,
  input  logic signed [31:0] req0_operand_a,
  input  logic signed [31:0] req0_operand_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [3:0]         req1_opcode,
  input  logic signed [31:0] req1_operand_a,
  input  logic signed [31:0] req1_operand_b,
  output logic               req1_ready,
  input  logic               clear,
  input  logic               rd_next,
  output logic               load_en,
  output logic [3:0]         opcode,
  output logic signed [31:0] operand_a,
  output logic signed [31:0] operand_b,
  output logic [4:0]         write_pointer,
  output logic [4:0]         read_pointer,
  output logic [5:0]         count,
  output logic               full
);

  localparam logic [4:0] PTR_MASK = 5'(DEPTH - 1);
  localparam logic [5:0] DEPTH_C  = 6'(DEPTH);

  logic               load_en_q, load_en_d;
  logic [3:0]         opcode_q, opcode_d;
  logic signed [31:0] operand_a_q, operand_a_d;
  logic signed [31:0] operand_b_q, operand_b_d;
  logic [4:0]         write_pointer_q, write_pointer_d;
  logic [4:0]         wr_ptr_q, wr_ptr_d;
  logic [4:0]         rd_ptr_q, rd_ptr_d;
  logic [5:0]         count_q, count_d;
  logic               last_grant_q, last_grant_d;

  logic full_w;
  logic accept_ok;
  logic grant0;
  logic grant1;

  assign full_w = (count_q == DEPTH_C);

  // Readies are gated by reset_n so they drop immediately while reset is held.
  always_comb begin
    accept_ok = reset_n && !clear && (!full_w || OVERWRITE);
    grant0    = accept_ok && req0_valid && (!req1_valid || last_grant_q);
    grant1    = accept_ok && req1_valid && (!req0_valid || !last_grant_q);
  end

  always_comb begin
    load_en_d       = 1'b0;
    opcode_d        = opcode_q;
    operand_a_d     = operand_a_q;
    operand_b_d     = operand_b_q;
    write_pointer_d = write_pointer_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    last_grant_d    = last_grant_q;
    if (clear) begin
      wr_ptr_d     = 5'd0;
      rd_ptr_d     = 5'd0;
      count_d      = 6'd0;
      last_grant_d = 1'b1;
    end else begin
      if (grant0 || grant1) begin
        load_en_d       = 1'b1;
        opcode_d        = grant0 ? req0_opcode    : req1_opcode;
        operand_a_d     = grant0 ? req0_operand_a : req1_operand_a;
        operand_b_d     = grant0 ? req0_operand_b : req1_operand_b;
        write_pointer_d = wr_ptr_q;
        wr_ptr_d        = (wr_ptr_q + 5'd1) & PTR_MASK;
        if (!full_w) count_d = count_q + 6'd1;
        last_grant_d    = grant1;
      end
      if (rd_next) rd_ptr_d = (rd_ptr_q + 5'd1) & PTR_MASK;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_en_q       <= 1'b0;
      opcode_q        <= 4'd0;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      write_pointer_q <= 5'd0;
      wr_ptr_q        <= 5'd0;
      rd_ptr_q        <= 5'd0;
      count_q         <= 6'd0;
      last_grant_q    <= 1'b1;
    end else begin
      load_en_q       <= load_en_d;
      opcode_q        <= opcode_d;
      operand_a_q     <= operand_a_d;
      operand_b_q     <= operand_b_d;
      write_pointer_q <= write_pointer_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      last_grant_q    <= last_grant_d;
    end
  end

  assign req0_ready    = grant0;
  assign req1_ready    = grant1;
  assign load_en       = load_en_q;
  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign write_pointer = write_pointer_q;
  assign read_pointer  = rd_ptr_q;
  assign count         = count_q;
  assign full          = full_w;

endmodule

// File: tb/tb_instr_register_arbiter.sv
// tb/tb_instr_register_arbiter.sv - scoreboard bench for instr_register_arbiter
// (stall and overwrite instances share the same stimulus).
module tb_instr_register_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               req0_valid, req1_valid;
  logic [3:0]         req0_opcode, req1_opcode;
  logic signed [31:0] req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic               clear, rd_next;

  logic               r0_ready[2], r1_ready[2], load_en[2], full[2];
  logic [3:0]         opcode[2];
  logic signed [31:0] operand_a[2], operand_b[2];
  logic [4:0]         write_pointer[2], read_pointer[2];
  logic [5:0]         count[2];

  instr_register_arbiter #(.DEPTH(32), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b), .req0_ready(r0_ready[0]),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b), .req1_ready(r1_ready[0]),
    .clear(clear), .rd_next(rd_next), .load_en(load_en[0]), .opcode(opcode[0]),
    .operand_a(operand_a[0]), .operand_b(operand_b[0]), .write_pointer(write_pointer[0]),
    .read_pointer(read_pointer[0]), .count(count[0]), .full(full[0])
  );

  instr_register_arbiter #(.DEPTH(32), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode),
    .req0_operand_a(req0_operand_a), .req0_operand_b(req0_operand_b), .req0_ready(r0_ready[1]),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode),
    .req1_operand_a(req1_operand_a), .req1_operand_b(req1_operand_b), .req1_ready(r1_ready[1]),
    .clear(clear), .rd_next(rd_next), .load_en(load_en[1]), .opcode(opcode[1]),
    .operand_a(operand_a[1]), .operand_b(operand_b[1]), .write_pointer(write_pointer[1]),
    .read_pointer(read_pointer[1]), .count(count[1]), .full(full[1])
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wp;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (id == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    if (id == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    if (have) begin
      chk($sformatf("dut%0d load_en", id), 32'(load_en[id]), 32'd1);
      chk($sformatf("dut%0d opcode", id), 32'(opcode[id]), 32'(e.op));
      chk($sformatf("dut%0d operand_a", id), operand_a[id], e.a);
      chk($sformatf("dut%0d operand_b", id), operand_b[id], e.b);
      chk($sformatf("dut%0d write_pointer", id), 32'(write_pointer[id]), 32'(e.wp));
    end else if (load_en[id] !== 1'b0) begin
      chk($sformatf("dut%0d spurious load_en", id), 32'(load_en[id]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic push(input bit to0, input bit to1, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] wp);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.wp = wp; e.due = cyc + 1;
    if (to0) q0.push_back(e);
    if (to1) q1.push_back(e);
  endtask

  task automatic chk_ready(input int id, input logic e0, input logic e1);
    chk($sformatf("dut%0d req0_ready", id), 32'(r0_ready[id]), 32'(e0));
    chk($sformatf("dut%0d req1_ready", id), 32'(r1_ready[id]), 32'(e1));
  endtask

  task automatic set_req(input logic v0, input logic v1);
    req0_valid = v0;
    req1_valid = v1;
  endtask

  initial begin
    logic g_seq[4];
    logic ow_seq[2];
    reset_n = 1'b0; clear = 1'b0; rd_next = 1'b0;
    set_req(1'b1, 1'b0);
    req0_opcode = 4'd0; req0_operand_a = 0; req0_operand_b = 0;
    req1_opcode = 4'd0; req1_operand_a = 0; req1_operand_b = 0;

    // reset state, readies low while in reset even with a valid request
    @(negedge clk); @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk_ready(d, 1'b0, 1'b0);
      chk($sformatf("dut%0d reset load_en", d), 32'(load_en[d]), 0);
      chk($sformatf("dut%0d reset count", d), 32'(count[d]), 0);
      chk($sformatf("dut%0d reset full", d), 32'(full[d]), 0);
      chk($sformatf("dut%0d reset wp", d), 32'(write_pointer[d]), 0);
      chk($sformatf("dut%0d reset rp", d), 32'(read_pointer[d]), 0);
      chk($sformatf("dut%0d reset opcode", d), 32'(opcode[d]), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    set_req(1'b0, 1'b0);

    // single requester: PASSA a=5 b=3
    @(negedge clk);
    set_req(1'b1, 1'b0);
    req0_opcode = 4'd1; req0_operand_a = 5; req0_operand_b = 3;
    #1;
    chk_ready(0, 1'b1, 1'b0);
    chk_ready(1, 1'b1, 1'b0);
    push(1, 1, 4'd1, 32'd5, 32'd3, 5'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0);
    #1;
    chk("dut0 count after single", 32'(count[0]), 1);

    // fresh reset so both-valid grants start from requester 0
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;

    g_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(1'b1, 1'b1);
      req0_opcode = 4'(i + 2); req0_operand_a = 10 + i; req0_operand_b = 20 + i;
      req1_opcode = 4'(i + 8); req1_operand_a = 30 + i; req1_operand_b = 40 + i;
      #1;
      chk_ready(0, !g_seq[i], g_seq[i]);
      chk_ready(1, !g_seq[i], g_seq[i]);
      if (!g_seq[i]) push(1, 1, 4'(i + 2), 32'(10 + i), 32'(20 + i), 5'(i));
      else           push(1, 1, 4'(i + 8), 32'(30 + i), 32'(40 + i), 5'(i));
    end

    // fill to 32 from requester 0 only
    for (int i = 4; i < 32; i++) begin
      @(negedge clk);
      set_req(1'b1, 1'b0);
      req0_opcode = 4'hA; req0_operand_a = i; req0_operand_b = -i;
      #1;
      chk_ready(0, 1'b1, 1'b0);
      push(1, 1, 4'hA, 32'(i), 32'(-i), 5'(i));
    end

    // both full; stall instance blocks, overwrite instance wraps to slots 0,1
    ow_seq = '{1'b1, 1'b0};
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      set_req(1'b1, 1'b1);
      req0_opcode = 4'h3; req0_operand_a = 100 + j; req0_operand_b = 200 + j;
      req1_opcode = 4'h5; req1_operand_a = 300 + j; req1_operand_b = 400 + j;
      #1;
      chk("dut0 full", 32'(full[0]), 1);
      chk("dut0 count full", 32'(count[0]), 32);
      chk_ready(0, 1'b0, 1'b0);
      chk_ready(1, !ow_seq[j], ow_seq[j]);
      if (ow_seq[j]) push(0, 1, 4'h5, 32'(300 + j), 32'(400 + j), 5'(j));
      else           push(0, 1, 4'h3, 32'(100 + j), 32'(200 + j), 5'(j));
    end
    @(negedge clk);
    #1;
    chk("dut1 count saturated", 32'(count[1]), 32);
    chk("dut1 full", 32'(full[1]), 1);
    chk_ready(0, 1'b0, 1'b0);

    // clear with valids held: readies drop, then the next grant lands in slot 0
    clear = 1'b1;
    #1;
    chk_ready(0, 1'b0, 1'b0);
    chk_ready(1, 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b0;
    set_req(1'b1, 1'b0);
    req0_opcode = 4'h7; req0_operand_a = -7; req0_operand_b = 77;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d count after clear", d), 32'(count[d]), 0);
      chk($sformatf("dut%0d full after clear", d), 32'(full[d]), 0);
      chk_ready(d, 1'b1, 1'b0);
    end
    push(1, 1, 4'h7, 32'hFFFF_FFF9, 32'd77, 5'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0);
    #1;
    chk("dut0 count after post-clear write", 32'(count[0]), 1);

    // read pointer wrap over 33 pulses
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      rd_next = 1'b1;
      if (i == 33) begin
        #1;
        chk("rp after 32 pulses", 32'(read_pointer[0]), 0);
      end
    end
    @(negedge clk);
    rd_next = 1'b0;
    #1;
    chk("rp after 33 pulses", 32'(read_pointer[0]), 1);
    @(negedge clk);
    clear = 1'b1; rd_next = 1'b1;
    @(negedge clk);
    clear = 1'b0; rd_next = 1'b0;
    #1;
    chk("rp clear beats rd_next", 32'(read_pointer[0]), 0);
    chk("dut1 rp clear beats rd_next", 32'(read_pointer[1]), 0);

    // two writes then asynchronous reset while load_en is high
    @(negedge clk);
    set_req(1'b1, 1'b0); rd_next = 1'b1;
    req0_opcode = 4'h2; req0_operand_a = 1; req0_operand_b = 2;
    #1;
    push(1, 1, 4'h2, 32'd1, 32'd2, 5'd0);
    @(negedge clk);
    rd_next = 1'b0;
    req0_opcode = 4'h4; req0_operand_a = 3; req0_operand_b = 4;
    #1;
    chk_ready(0, 1'b1, 1'b0);
    push(1, 1, 4'h4, 32'd3, 32'd4, 5'd1);
    @(negedge clk);
    set_req(1'b0, 1'b0);
    #1;
    chk("count before reset", 32'(count[0]), 2);
    chk("rp before reset", 32'(read_pointer[0]), 1);
    chk("load_en before reset", 32'(load_en[0]), 1);
    #1;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d async load_en", d), 32'(load_en[d]), 0);
      chk($sformatf("dut%0d async count", d), 32'(count[d]), 0);
      chk($sformatf("dut%0d async wp", d), 32'(write_pointer[d]), 0);
      chk($sformatf("dut%0d async rp", d), 32'(read_pointer[d]), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("dut0 scoreboard drained", 32'(q0.size()), 0);
    chk("dut1 scoreboard drained", 32'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_register_arbiter.md
# instr_register_arbiter

Two-port write arbiter and pointer sequencer that sits in front of `instr_register`. Two independent requesters (e.g. stimulus generator and directed-test port) present instruction triples over valid/ready handshakes. The block grants them round-robin, allocates consecutive write slots, and drives `load_en`, `opcode`, `operand_a`, `operand_b` and `write_pointer` into the register. It also owns the read pointer, provides an occupancy count, and flags full.

## Interface
- `DEPTH`, 32: number of register slots used; 2..32, power of two; pointers wrap modulo `DEPTH`.
- `OVERWRITE`, 0: 0 = stall requesters when full; 1 = keep accepting, wrap and overwrite the oldest slots.

Ports:
- `clk`  in  1  single clock, all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an instruction.
- `req0_opcode`  in  opcode_t (4)  requester 0 opcode.
- `req0_operand_a`, `req0_operand_b`  in  operand_t (32, signed)  requester 0 operands.
- `req0_ready`  out  1  requester 0 granted this cycle.
- `req1_valid`, `req1_opcode`, `req1_operand_a`, `req1_operand_b`, `req1_ready`: same for requester 1.
- `clear`  in  1  synchronous clear of pointers, count and arbitration state.
- `rd_next`  in  1  advance the read pointer by one.
- `load_en`  out  1  write strobe to the register (registered).
- `opcode`  out  opcode_t  latched opcode of the granted request.
- `operand_a`, `operand_b`  out  operand_t  latched operands.
- `write_pointer`  out  address_t (5)  slot to be written with `load_en`.
- `read_pointer`  out  address_t (5)  current read slot.
- `count`  out  6  slots written since reset/clear; saturates at `DEPTH`.
- `full`  out  1  `count == DEPTH`.

## Operation
- State: `wr_ptr`, `read_pointer`, `count`, `last_grant` (1 bit), plus output registers.
- Acceptance allowed when `!clear && (!full || OVERWRITE)`.
- Arbitration, combinational from the current valids and registered `last_grant`:
  - only one valid: that requester gets ready;
  - both valid: the requester != `last_grant` gets ready.
  - At most one ready is high per cycle.
- Handshake = `reqN_valid && reqN_ready` at a posedge. At that edge:
  - output fields <= requester N fields;
  - `write_pointer` <= `wr_ptr`;
  - `load_en` <= 1;
  - `wr_ptr` <= (`wr_ptr`+1) mod `DEPTH`;
  - `count` <= min(`count`+1, `DEPTH`);
  - `last_grant` <= N.
- No handshake at an edge: `load_en` <= 0; the other output fields hold.
- `rd_next` at an edge: `read_pointer` <= (`read_pointer`+1) mod `DEPTH`. It is independent of `count` and the block does no underflow checking.
- `clear` at an edge:
  - `wr_ptr`, `read_pointer`, `count` <= 0; `last_grant` <= 1;
  - both readies are 0 that cycle;
  - `load_en` <= 0. A load already presented this cycle still completes in the register.
  - `clear` has priority over `rd_next`.
- Full with `OVERWRITE=0`: both readies stay 0 until `clear` or reset.
- Full with `OVERWRITE=1`: acceptance continues, `wr_ptr` wraps from `DEPTH-1` to 0, and `count` stays at `DEPTH`.

## Timing
- Reset (async, `reset_n` low) sets:
  - `load_en`=0, `opcode`=ZERO, `operand_a`=`operand_b`=0;
  - `write_pointer`=`read_pointer`=0, `count`=0, `full`=0;
  - `last_grant`=1, so requester 0 wins the first tie.
- Readies are combinational and go low immediately while `reset_n` is low.
- Reset mid-operation: a pending `load_en` is dropped immediately and the granted instruction is lost.
- Latency:
  - handshake at edge N;
  - `load_en`/fields/`write_pointer` valid between N and N+1;
  - register written at edge N+1.
- Throughput: one instruction per cycle, back-to-back; `load_en` stays high on consecutive grants.
- `full` rises in the cycle after the handshake that makes `count == DEPTH`.

## Test plan
- Single requester, reset then `req0_valid` with PASSA, a=5, b=3 for one cycle -> `req0_ready`=1. Next cycle `load_en`=1, `write_pointer`=0, `operand_a`=5. `count`=1.
- Both valid continuously for 4 cycles -> grants 0,1,0,1. `write_pointer` 0,1,2,3; `load_en` high 4 consecutive cycles.
- `OVERWRITE=0`, 32 accepted writes -> `full`=1, `count`=32, both readies 0 with valids held. Then `clear` -> `count`=0, next grant gets `write_pointer`=0.
- `OVERWRITE=1`, 34 writes -> `write_pointer` sequence …30,31,0,1; `count` stays 32; `full`=1.
- `rd_next` pulsed 33 times -> `read_pointer` wraps 31->0 and ends at 1. `clear` asserted together with `rd_next` -> `read_pointer`=0.
- Assert `reset_n`=0 in the cycle after a handshake (while `load_en`=1) -> `load_en`, `count` and pointers go to 0 immediately, without waiting for `clk`.
